// File: rtl/gcd_pkg.sv
// Shared definitions for the subtraction-based GCD controller and its datapath.
package gcd_pkg;

  // Default datapath operand width.
  localparam int GCD_DATA_BITS = 4;

  // Controller states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } gcd_state_e;

  // Width of a counter that must hold 0..max_iter inclusive.
  function automatic int iter_width(input int max_iter);
    return $clog2(max_iter + 1);
  endfunction

endpackage

// File: rtl/gcd_controller.sv
// Control FSM for the subtraction-based GCD datapath. It loads the operands on
// an accepted start and then steps compare/subtract, one subtraction per
// cycle, until the operands are equal. It then latches the result and holds
// done until ack. An iteration guard aborts the runs that would never
// terminate, such as those with a zero operand.
module gcd_controller
  import gcd_pkg::*;
#(
  parameter  int DATA_BITS = GCD_DATA_BITS,
  parameter  int MAX_ITER  = 2 ** DATA_BITS,
  localparam int IW        = iter_width(MAX_ITER)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  input  logic          ack_i,
  input  logic          xbig_i,
  input  logic          ybig_i,
  input  logic          eq_i,
  output logic          sx_o,
  output logic          sy_o,
  output logic          ssub_o,
  output logic          enx_o,
  output logic          eny_o,
  output logic          enobeb_o,
  output logic          ready_o,
  output logic          done_o,
  output logic          err_o,
  output logic [IW-1:0] iter_o
);

  localparam logic [IW-1:0] ITER_LIMIT = IW'(MAX_ITER);

  gcd_state_e    state_q;
  logic [IW-1:0] iter_q;
  logic          err_q;
  logic          at_limit;
  logic          abort;

  // The abort path is taken on an exhausted budget, or when no flag is set
  // (an illegal flag combination that would otherwise stall in RUN).
  assign at_limit = (iter_q == ITER_LIMIT);
  assign abort    = at_limit || !(xbig_i || ybig_i);

  // State, iteration counter and error flag.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      iter_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_q <= RUN;
            iter_q  <= '0;
            err_q   <= 1'b0;
          end
        end
        RUN: begin
          if (eq_i) begin
            state_q <= DONE;
            err_q   <= 1'b0;
          end else if (abort) begin
            state_q <= DONE;
            err_q   <= 1'b1;
          end else if (!at_limit) begin
            // Saturating: the abort branch catches the limit before any wrap.
            iter_q <= iter_q + 1'b1;
          end
        end
        DONE: begin
          if (ack_i) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Mealy datapath controls from state, flags and counter.
  // NOTE: every output gets a default before the case, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    sx_o     = 1'b0;
    sy_o     = 1'b0;
    ssub_o   = 1'b0;
    enx_o    = 1'b0;
    eny_o    = 1'b0;
    enobeb_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          // sx/sy = 0 selects the external operands.
          enx_o = 1'b1;
          eny_o = 1'b1;
        end
      end
      RUN: begin
        if (eq_i) begin
          enobeb_o = 1'b1;
        end else if (!abort) begin
          if (xbig_i) begin
            sx_o  = 1'b1;
            enx_o = 1'b1;
          end else begin
            sy_o   = 1'b1;
            eny_o  = 1'b1;
            ssub_o = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  assign ready_o = (state_q == IDLE);
  assign done_o  = (state_q == DONE);
  assign err_o   = err_q;
  assign iter_o  = iter_q;

endmodule
